// File: rtl/i2s_pkg.sv
// Shared constants, state encodings and sample types for the I2S frame controller.
// Optional build macro: I2S_LEFT_JUSTIFIED_EN (left-justified capture, no 1-bit delay).
package i2s_pkg;

  localparam int unsigned I2S_DATA_BITS = 24;
  localparam int unsigned I2S_SLOT_BITS = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  typedef logic [I2S_DATA_BITS-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

endpackage

// File: rtl/i2s_clk_div.sv
// bck/lrck generator and slot sequencer; emits sample, falling-bck and slot-wrap strobes
// that are valid during the cycle before the mck edge they describe.
module i2s_clk_div
  import i2s_pkg::*;
#(
  parameter int unsigned MCK_PER_BCK = 4,
  parameter int unsigned SLOT_BITS   = I2S_SLOT_BITS,
  localparam int unsigned DIV_W      = $clog2(MCK_PER_BCK),
  localparam int unsigned BIT_W      = $clog2(SLOT_BITS)
) (
  input  logic             mck,
  input  logic             rst,
  input  logic             en,
  output logic [1:0]       state,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             bck,
  output logic             lrck,
  output logic             sample_evt,
  output logic             bck_fall,
  output logic             slot_wrap
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCK_PER_BCK - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCK_PER_BCK / 2);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(MCK_PER_BCK / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_BITS - 1);

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             bck_q, bck_d;
  logic             lrck_q, lrck_d;
  logic             running;

  assign running    = (state_q != ST_IDLE);
  assign sample_evt = en && running && (div_q == DIV_PRE);
  assign bck_fall   = en && running && (div_q == DIV_LAST);
  assign slot_wrap  = bck_fall && (bit_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    if (!en) begin
      state_d = ST_IDLE;
      div_d   = '0;
      bit_d   = '0;
    end else if (!running) begin
      state_d = ST_LEFT;
    end else begin
      div_d = bck_fall ? '0 : div_q + 1'b1;
      if (bck_fall) begin
        bit_d = slot_wrap ? '0 : bit_q + 1'b1;
      end
      if (slot_wrap) begin
        state_d = (state_q == ST_LEFT) ? ST_RIGHT : ST_LEFT;
      end
    end
    // Registered from next-state so bck/lrck edges land on the same mck edge as the counters.
    bck_d  = (state_d != ST_IDLE) && (div_d >= DIV_HALF);
    lrck_d = (state_d == ST_RIGHT);
  end

  always_ff @(posedge mck or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      bck_q   <= 1'b0;
      lrck_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      bck_q   <= bck_d;
      lrck_q  <= lrck_d;
    end
  end

  assign state   = state_q;
  assign bit_cnt = bit_q;
  assign bck     = bck_q;
  assign lrck    = lrck_q;

endmodule

// File: rtl/i2s_frame_ctrl.sv
// Master-mode I2S receiver: deserialises left/right words and offers stereo pairs on a
// valid/ready handshake with sticky overrun. Define I2S_LEFT_JUSTIFIED_EN for left-justified.
module i2s_frame_ctrl
  import i2s_pkg::*;
#(
  parameter int unsigned MCK_PER_BCK = 4,
  parameter int unsigned SLOT_BITS   = I2S_SLOT_BITS,
  parameter int unsigned DATA_BITS   = I2S_DATA_BITS,
  localparam int unsigned BIT_W      = $clog2(SLOT_BITS)
) (
  input  logic                 mck,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sdata_in,
  output logic                 bck,
  output logic                 lrck,
  output logic [BIT_W-1:0]     bit_count,
  output logic [DATA_BITS-1:0] left_out,
  output logic [DATA_BITS-1:0] right_out,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 overrun
);

`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam int unsigned FIRST_BIT = 0;
`else
  localparam int unsigned FIRST_BIT = 1;
`endif

  localparam logic [BIT_W-1:0] FIRST_IDX = BIT_W'(FIRST_BIT);
  localparam logic [BIT_W-1:0] LAST_IDX  = BIT_W'(DATA_BITS - 1);

  logic [1:0]           state;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 sample_evt, bck_fall, slot_wrap;
  logic [BIT_W-1:0]     bit_idx;
  logic                 in_word, word_last;
  logic [DATA_BITS-1:0] word_next;

  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] left_hold_q, left_hold_d;
  logic                 left_full_q, left_full_d;
  logic                 pair_done_q, pair_done_d;
  logic [DATA_BITS-1:0] left_out_q, left_out_d;
  logic [DATA_BITS-1:0] right_out_q, right_out_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  i2s_clk_div #(
    .MCK_PER_BCK(MCK_PER_BCK),
    .SLOT_BITS  (SLOT_BITS)
  ) u_clk_div (
    .mck       (mck),
    .rst       (rst),
    .en        (en),
    .state     (state),
    .bit_cnt   (bit_cnt),
    .bck       (bck),
    .lrck      (lrck),
    .sample_evt(sample_evt),
    .bck_fall  (bck_fall),
    .slot_wrap (slot_wrap)
  );

  // Slot bits before FIRST_BIT wrap to large indices and fall outside the capture window.
  assign bit_idx   = bit_cnt - FIRST_IDX;
  assign in_word   = (bit_idx <= LAST_IDX);
  assign word_last = (bit_idx == LAST_IDX);
  assign word_next = {shreg_q[DATA_BITS-2:0], sdata_in};

  always_comb begin
    shreg_d     = shreg_q;
    left_hold_d = left_hold_q;
    left_full_d = left_full_q;
    pair_done_d = 1'b0;
    if (!en) begin
      shreg_d     = '0;
      left_full_d = 1'b0;
    end else begin
      if (sample_evt && in_word) begin
        shreg_d = word_next;
        if (word_last) begin
          if (state == ST_LEFT) begin
            left_hold_d = word_next;
            left_full_d = 1'b1;
          end else if (left_full_q) begin
            pair_done_d = 1'b1;
            left_full_d = 1'b0;
          end
        end
      end
      // Keep the shifter empty outside the capture window so no stale bits leak into a word.
      if (bck_fall && word_last) begin
        shreg_d = '0;
      end
      if (slot_wrap && (state == ST_RIGHT)) begin
        left_full_d = 1'b0;
      end
    end
  end

  always_comb begin
    left_out_d  = left_out_q;
    right_out_d = right_out_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    if (pair_done_q) begin
      if (!valid_q || sample_ready) begin
        left_out_d  = left_hold_q;
        right_out_d = shreg_q;
        valid_d     = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
    if (!en) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge mck or posedge rst) begin
    if (rst) begin
      shreg_q     <= '0;
      left_hold_q <= '0;
      left_full_q <= 1'b0;
      pair_done_q <= 1'b0;
      left_out_q  <= '0;
      right_out_q <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      left_hold_q <= left_hold_d;
      left_full_q <= left_full_d;
      pair_done_q <= pair_done_d;
      left_out_q  <= left_out_d;
      right_out_q <= right_out_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bit_count    = bit_cnt;
  assign left_out     = left_out_q;
  assign right_out    = right_out_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Scoreboard bench for i2s_frame_ctrl: codec model drives sdata_in, a monitor checks each
// transferred pair against the expected queue. Honours I2S_LEFT_JUSTIFIED_EN.
module tb_i2s_frame_ctrl;
  import i2s_pkg::*;

`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam int OFF = 0;
  localparam int LD  = 224;
`else
  localparam int OFF = 1;
  localparam int LD  = 228;
`endif

  logic        mck = 1'b0;
  logic        rst, en, sdata_in, sample_ready;
  logic        bck, lrck, sample_valid, overrun;
  logic [4:0]  bit_count;
  sample_t     left_out, right_out;

  i2s_frame_ctrl #(
    .MCK_PER_BCK(4),
    .SLOT_BITS  (32),
    .DATA_BITS  (24)
  ) dut (
    .mck         (mck),
    .rst         (rst),
    .en          (en),
    .sdata_in    (sdata_in),
    .bck         (bck),
    .lrck        (lrck),
    .bit_count   (bit_count),
    .left_out    (left_out),
    .right_out   (right_out),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun     (overrun)
  );

  always #5 mck = ~mck;

  stereo_t exp_q[$];
  int      n_pass = 0;
  int      n_total = 0;
  int      c = 0;
  sample_t nxt_l = '0;
  sample_t nxt_r = '0;
  sample_t cur_l, cur_r;
  logic    pb, pl;
  int      last_rise, last_lrise, vcount, first_v;
  bit      done_p, done_h;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge mck);
    c++;
  endtask

  task automatic tick_to(input int t);
    while (c < t) tick();
  endtask

  task automatic start_en();
    en = 1'b1;
    c  = 0;
  endtask

  task automatic push_pair(input sample_t l, input sample_t r);
    stereo_t p;
    p.left  = l;
    p.right = r;
    exp_q.push_back(p);
  endtask

  function automatic logic codec_bit(input sample_t w, input logic [4:0] b);
    int idx;
    idx = int'(b) - OFF;
    if (idx >= 0 && idx < 24) return w[23-idx];
    return 1'b1;  // ignored slot bits driven high so a misplaced capture shows up
  endfunction

  // Codec: left word latched during the right slot, right word during the left slot.
  initial begin
    sdata_in = 1'b1;
    cur_l    = '0;
    cur_r    = '0;
    forever begin
      @(negedge mck);
      if (lrck || !en) cur_l = nxt_l;
      if (!lrck) cur_r = nxt_r;
      sdata_in = codec_bit(lrck ? cur_r : cur_l, bit_count);
    end
  end

  initial begin
    stereo_t e;
    forever begin
      @(negedge mck);
      #1;
      if (!rst && sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_pair: got %h/%h, required no transfer", left_out, right_out);
        end else begin
          e = exp_q.pop_front();
          check("pair_left", 32'(left_out), 32'(e.left));
          check("pair_right", 32'(right_out), 32'(e.right));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    sample_ready = 1'b0;
    repeat (3) @(negedge mck);
    check("rst_bck", 32'(bck), 0);
    check("rst_lrck", 32'(lrck), 0);
    check("rst_bit_count", 32'(bit_count), 0);
    check("rst_left", 32'(left_out), 0);
    check("rst_right", 32'(right_out), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    repeat (4) @(negedge mck);

    // Clock shape and basic capture
    nxt_l = 24'h888888;
    nxt_r = 24'h123456;
    sample_ready = 1'b1;
    push_pair(24'h888888, 24'h123456);
    push_pair(24'h888888, 24'h123456);
    repeat (4) @(negedge mck);
    start_en();
    pb = 1'b0; pl = 1'b0;
    last_rise = -1; last_lrise = -1; vcount = 0; first_v = -1;
    done_p = 1'b0; done_h = 1'b0;
    while (c < 600) begin
      tick();
      if (bck && !pb) begin
        if (last_rise >= 0 && !done_p) begin
          check("bck_period", c - last_rise, 4);
          done_p = 1'b1;
        end
        last_rise = c;
      end
      if (!bck && pb && !done_h) begin
        check("bck_high", c - last_rise, 2);
        done_h = 1'b1;
      end
      if (lrck != pl) check("lrck_toggle_on_bck_fall", 32'({pb, bck}), 2);
      if (lrck && !pl) begin
        if (last_lrise >= 0) check("lrck_period", c - last_lrise, 256);
        last_lrise = c;
      end
      if (c == 44) check("bit_count_10", 32'(bit_count), 10);
      if (sample_valid) begin
        vcount++;
        if (first_v < 0) begin
          first_v = c;
          check("basic_left", 32'(left_out), 32'h888888);
          check("basic_right", 32'(right_out), 32'h123456);
        end
      end
      pb = bck;
      pl = lrck;
    end
    check("first_valid_cycle", first_v, LD);
    check("valid_cycles", vcount, 2);
    en = 1'b0;
    repeat (8) tick();

    // Backpressure: three completions, only the first is kept
    sample_ready = 1'b0;
    nxt_l = 24'hA5A5A5;
    nxt_r = 24'h000001;
    push_pair(24'hA5A5A5, 24'h000001);
    repeat (4) tick();
    start_en();
    tick_to(200);
    nxt_r = 24'h000002;
    tick_to(456);
    nxt_r = 24'h000003;
    tick_to(LD);
    check("bp1_valid", 32'(sample_valid), 1);
    check("bp1_right", 32'(right_out), 1);
    check("bp1_overrun", 32'(overrun), 0);
    tick_to(LD + 255);
    check("bp_overrun_before_2nd", 32'(overrun), 0);
    tick_to(LD + 256);
    check("bp2_overrun", 32'(overrun), 1);
    check("bp2_right", 32'(right_out), 1);
    tick_to(LD + 512);
    check("bp3_overrun", 32'(overrun), 1);
    check("bp3_right", 32'(right_out), 1);
    check("bp3_left", 32'(left_out), 32'hA5A5A5);
    tick_to(LD + 513);
    sample_ready = 1'b1;
    tick_to(LD + 514);
    check("bp_drained", 32'(sample_valid), 0);
    en = 1'b0;
    tick_to(LD + 515);
    check("bp_overrun_cleared", 32'(overrun), 0);
    check("bp_left_held", 32'(left_out), 32'hA5A5A5);
    repeat (8) tick();

    // Transfer and completion on the same edge
    sample_ready = 1'b0;
    nxt_l = 24'h0F0F0F;
    nxt_r = 24'h00AAAA;
    push_pair(24'h0F0F0F, 24'h00AAAA);
    push_pair(24'h0F0F0F, 24'h00BBBB);
    repeat (4) tick();
    start_en();
    tick_to(200);
    nxt_r = 24'h00BBBB;
    tick_to(LD);
    check("sim1_right", 32'(right_out), 32'h00AAAA);
    tick_to(LD + 255);
    sample_ready = 1'b1;
    tick_to(LD + 256);
    sample_ready = 1'b0;
    check("sim_valid", 32'(sample_valid), 1);
    check("sim_right", 32'(right_out), 32'h00BBBB);
    check("sim_left", 32'(left_out), 32'h0F0F0F);
    check("sim_overrun", 32'(overrun), 0);
    tick_to(LD + 260);
    sample_ready = 1'b1;
    tick_to(LD + 261);
    check("sim_drained", 32'(sample_valid), 0);
    en = 1'b0;
    repeat (8) tick();

    // en dropped mid-left at bit 10, raised 50 cycles later
    nxt_l = 24'h111111;
    nxt_r = 24'h222222;
    push_pair(24'h111111, 24'h222222);
    push_pair(24'h333333, 24'h444444);
    repeat (4) tick();
    start_en();
    tick_to(200);
    nxt_l = 24'h333333;
    nxt_r = 24'h444444;
    tick_to(297);
    check("drop_bit_count", 32'(bit_count), 10);
    check("drop_lrck_left", 32'(lrck), 0);
    en = 1'b0;
    tick_to(298);
    check("drop_bck", 32'(bck), 0);
    check("drop_lrck", 32'(lrck), 0);
    check("drop_bit_count_zero", 32'(bit_count), 0);
    check("drop_left_held", 32'(left_out), 32'h111111);
    check("drop_right_held", 32'(right_out), 32'h222222);
    tick_to(347);
    start_en();
    vcount = 0;
    while (c < LD - 1) begin
      tick();
      if (sample_valid) vcount++;
      if (c == 100) check("reen_left_held", 32'(left_out), 32'h111111);
    end
    check("reen_no_early_pair", vcount, 0);
    tick();
    check("reen_valid", 32'(sample_valid), 1);
    check("reen_left", 32'(left_out), 32'h333333);
    check("reen_right", 32'(right_out), 32'h444444);
    en = 1'b0;
    repeat (8) tick();
    check("queue_drained", exp_q.size(), 0);

    // Asynchronous reset mid-right-slot
    sample_ready = 1'b0;
    nxt_l = 24'h5A5A5A;
    nxt_r = 24'h654321;
    repeat (4) tick();
    start_en();
    tick_to(700);
    check("pre_rst_valid", 32'(sample_valid), 1);
    check("pre_rst_overrun", 32'(overrun), 1);
    check("pre_rst_lrck", 32'(lrck), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_bck", 32'(bck), 0);
    check("arst_lrck", 32'(lrck), 0);
    check("arst_bit_count", 32'(bit_count), 0);
    check("arst_valid", 32'(sample_valid), 0);
    check("arst_overrun", 32'(overrun), 0);
    check("arst_left", 32'(left_out), 0);
    check("arst_right", 32'(right_out), 0);
    en = 1'b0;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i2s_frame_ctrl.md
Name: i2s_frame_ctrl

Overview:
Master-mode I2S frame controller for the pedal's audio input path. Divides mck into bck and lrck and sequences the bit slots. Deserialises the 24-bit left/right words from the codec's serial data. Hands each completed stereo pair to the effects datapath over a valid/ready handshake, with sticky overrun detection.

Parameters:
MCK_PER_BCK, 4, mck cycles per bck period; even, >=2
SLOT_BITS, 32, bck periods per channel slot (frame = 2*SLOT_BITS)
DATA_BITS, 24, sample width captured per channel; DATA_BITS <= SLOT_BITS-1

Ports:
mck  in  1  master clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  run enable; low forces IDLE
sdata_in  in  1  serial data from codec
bck  out  1  bit clock
lrck  out  1  frame clock; 0 = left, 1 = right
bit_count  out  $clog2(SLOT_BITS)  current slot bit index
left_out  out  DATA_BITS  last completed left sample
right_out  out  DATA_BITS  last completed right sample
sample_valid  out  1  stereo pair available
sample_ready  in  1  consumer accepts pair
overrun  out  1  sticky: a pair was dropped

Behaviour:
- Reset (async): all outputs are 0; div_cnt, bit_cnt and the shift register are 0; state is IDLE.
- States:
  - IDLE: bck=0, lrck=0, counters held at 0. Moves to LEFT on the first mck edge with en=1.
  - LEFT: lrck=0.
  - RIGHT: lrck=1.
  - en=0 in LEFT or RIGHT returns to IDLE on the next edge. Any partial word is discarded; left_out, right_out, sample_valid and overrun are held.
- Clock division:
  - div_cnt counts 0..MCK_PER_BCK-1 and wraps.
  - bck = (div_cnt >= MCK_PER_BCK/2), registered.
  - Rising bck coincides with div_cnt reaching MCK_PER_BCK/2. sdata_in is registered on that same edge (the sample event).
  - Falling bck (div_cnt wrap) increments bit_cnt.
  - When bit_cnt wraps from SLOT_BITS-1 to 0, LEFT and RIGHT swap and lrck toggles together with the falling bck.
- Capture (standard I2S, 1-bit delay):
  - Slot bit 0 is ignored.
  - Bits 1..DATA_BITS are shifted in MSB first.
  - Bits above DATA_BITS are ignored.
- Word completion:
  - On the sample event of bit DATA_BITS in LEFT, the word goes to an internal left holding register.
  - On the sample event of bit DATA_BITS in RIGHT, the pair completes. One mck cycle later: left_out takes the held left word, right_out takes the right word, and sample_valid=1.
  - A RIGHT slot entered without a preceding full LEFT slot (first frame after en) produces no pair.
- Handshake:
  - A transfer occurs on an edge where sample_valid and sample_ready are both 1. sample_valid drops on that edge unless a new pair loads on it.
  - sample_valid is held, with data stable, until the transfer.
- Boundary cases:
  - A new pair completes while sample_valid=1 and sample_ready=0: the new pair is dropped, the outputs keep the old pair, and overrun goes to 1.
  - A pair completes on the same edge as a transfer: the new pair loads, sample_valid stays 1, and there is no overrun.
  - overrun clears only on rst or en=0.
  - rst asserted mid-frame: everything returns to its reset value immediately.

Optional Feature:
- I2S_LEFT_JUSTIFIED_EN defined: left-justified framing. There is no 1-bit delay; slot bits 0..DATA_BITS-1 are captured. All timing and the handshake are otherwise identical.
- Not defined: standard I2S with the 1-bit delay described above.

Decomposition:
- Package i2s_pkg holds:
  - DATA_BITS and SLOT_BITS defaults
  - the state enum (IDLE, LEFT, RIGHT)
  - the sample word typedef
- Sub-module i2s_clk_div contains div_cnt, bit_cnt, and the bck/lrck generation. It emits one-cycle strobes to the top: sample_evt, bck_fall, slot_wrap.
- Capture and handshake live in the top level.

Test Plan:
All scenarios use defaults (frame = 256 mck cycles).
- Clock check: rst pulse, en=1 -> bck period 4 mck, duty 50%; lrck period 256 mck; lrck toggles coincide with falling bck.
- Basic capture: drive left=0x888888, right=0x123456 with 1-bit delay, sample_ready=1 -> one mck after right bit 24 sampled: left_out=0x888888, right_out=0x123456, sample_valid high for exactly 1 cycle.
- Backpressure: sample_ready=0 for 3 frames with right words 0x000001, 0x000002, 0x000003 -> outputs stay at the first pair (right_out=0x000001) and overrun=1 from the second completion onward.
- Simultaneous events: assert sample_ready on exactly the cycle the next pair completes -> new pair loaded, sample_valid stays 1, overrun stays 0.
- en dropped mid-left-slot at bit 10, raised again 50 mck later -> bck/lrck return to 0; first valid pair only after a full LEFT+RIGHT; held outputs unchanged meanwhile.
- Async rst asserted between mck edges mid-right-slot -> bck, lrck, sample_valid, overrun and the data outputs read 0 before the next mck edge; with I2S_LEFT_JUSTIFIED_EN, rerun basic capture with unshifted data and get the same values.
